// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encoding, the NOP/bubble word
// and the control bundle that drives every pipe register, plus the RUN-state rules.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 4;

  // All-zero word loaded into IF/ID on flush and into ID/EX controls on bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DMISS  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
    logic exmem_en;
    logic memwb_en;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_FLOW = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                       idex_en: 1'b1, idex_bubble: 1'b0,
                                       exmem_en: 1'b1, memwb_en: 1'b1};
  localparam pipe_ctrl_t CTRL_FREEZE = '0;

  // Highest-priority cause wins; a taken branch overrides a pending fetch miss.
  function automatic pipe_ctrl_t run_ctrl(input logic dmem_stall, input logic idex_halt,
                                          input logic load_use, input logic branch_taken,
                                          input logic imem_stall);
    pipe_ctrl_t c;
    c = CTRL_FLOW;
    if (dmem_stall) begin
      c = CTRL_FREEZE;
    end else if (idex_halt) begin
      c.pc_en       = 1'b0;
      c.ifid_flush  = 1'b1;
      c.idex_bubble = 1'b1;
    end else if (load_use) begin
      c.pc_en       = 1'b0;
      c.ifid_en     = 1'b0;
      c.idex_bubble = 1'b1;
    end else if (branch_taken) begin
      c.ifid_flush = 1'b1;
    end else if (imem_stall) begin
      c.pc_en      = 1'b0;
      c.ifid_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use compare between the load sitting in ID/EX and the sources read in ID.
// Register 0 is hard-wired, so it never creates a dependency.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_src_reg1,
  input  logic [REG_W-1:0] i_src_reg2,
  input  logic             i_uses_src2,
  input  logic             i_mem_read,
  input  logic             i_write_reg,
  input  logic [REG_W-1:0] i_dst_reg,
  output logic             o_load_use
);

  logic w_dst_live;
  logic w_match;

  assign w_dst_live = i_mem_read & i_write_reg & (i_dst_reg != '0);
  assign w_match    = (i_dst_reg == i_src_reg1) | (i_uses_src2 & (i_dst_reg == i_src_reg2));
  assign o_load_use = w_dst_live & w_match;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: enables and flush/bubble strobes for all pipe
// registers, HALT drain sequencing and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int HALT_DRAIN = 2,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [REG_W-1:0] i_ifid_src_reg1,
  input  logic [REG_W-1:0] i_ifid_src_reg2,
  input  logic             i_ifid_uses_src2,
  input  logic             i_idex_mem_read,
  input  logic             i_idex_write_reg,
  input  logic [REG_W-1:0] i_idex_dst_reg,
  input  logic             i_idex_halt,
  input  logic             i_branch_taken,
  input  logic             i_imem_stall,
  input  logic             i_dmem_stall,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_en,
  output logic             o_idex_bubble,
  output logic             o_exmem_en,
  output logic             o_memwb_en,
  output logic             o_hlt,
  output logic [CNT_W-1:0] o_stall_cycles
);

  localparam int DRAIN_W = (HALT_DRAIN > 2) ? $clog2(HALT_DRAIN) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(HALT_DRAIN - 1);

  state_e             r_state;
  state_e             w_state_next;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [DRAIN_W-1:0] w_drain_next;
  logic [CNT_W-1:0]   r_stall_cycles;
  logic               w_load_use;
  pipe_ctrl_t         w_run_ctrl;
  pipe_ctrl_t         w_ctrl;

  pipe_hazard_ctrl_hazard_detect u_hazard_detect (
    .i_src_reg1  (i_ifid_src_reg1),
    .i_src_reg2  (i_ifid_src_reg2),
    .i_uses_src2 (i_ifid_uses_src2),
    .i_mem_read  (i_idex_mem_read),
    .i_write_reg (i_idex_write_reg),
    .i_dst_reg   (i_idex_dst_reg),
    .o_load_use  (w_load_use)
  );

  assign w_run_ctrl = run_ctrl(i_dmem_stall, i_idex_halt, w_load_use, i_branch_taken, i_imem_stall);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_next;
    end
  end

  // Leaving DMISS reuses the RUN decision, so a frozen hazard is acted on immediately.
  always_comb begin
    w_state_next = r_state;
    w_drain_next = r_drain_cnt;
    case (r_state)
      ST_RUN, ST_DMISS: begin
        if (i_dmem_stall) begin
          w_state_next = ST_DMISS;
        end else if (i_idex_halt) begin
          w_state_next = ST_DRAIN;
          w_drain_next = DRAIN_INIT;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!i_dmem_stall) begin
          if (r_drain_cnt == '0) begin
            w_state_next = ST_HALTED;
          end else begin
            w_drain_next = r_drain_cnt - 1'b1;
          end
        end
      end
      default: w_state_next = ST_HALTED;
    endcase
  end

  always_comb begin
    w_ctrl = CTRL_FLOW;
    if (i_rst_n) begin
      case (r_state)
        ST_RUN:   w_ctrl = w_run_ctrl;
        ST_DMISS: w_ctrl = i_dmem_stall ? CTRL_FREEZE : w_run_ctrl;
        ST_DRAIN: begin
          // Keep injecting NOPs behind the HALT while older instructions retire.
          w_ctrl.pc_en       = 1'b0;
          w_ctrl.ifid_flush  = 1'b1;
          w_ctrl.idex_bubble = 1'b1;
          w_ctrl.exmem_en    = ~i_dmem_stall;
          w_ctrl.memwb_en    = ~i_dmem_stall;
        end
        default:  w_ctrl = CTRL_FREEZE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stall_cycles <= '0;
    end else if (!w_ctrl.pc_en && (r_state != ST_HALTED) && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign o_pc_en        = w_ctrl.pc_en;
  assign o_ifid_en      = w_ctrl.ifid_en;
  assign o_ifid_flush   = w_ctrl.ifid_flush;
  assign o_idex_en      = w_ctrl.idex_en;
  assign o_idex_bubble  = w_ctrl.idex_bubble;
  assign o_exmem_en     = w_ctrl.exmem_en;
  assign o_memwb_en     = w_ctrl.memwb_en;
  assign o_hlt          = (r_state == ST_HALTED);
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// expected outputs produced by a behavioural model and checked by a monitor.
module tb_pipe_hazard_ctrl;

  localparam int HALT_DRAIN = 2;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  // Control vectors ordered {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en}.
  localparam logic [6:0] V_NORMAL = 7'b1101011;
  localparam logic [6:0] V_HALT   = 7'b0111111;
  localparam logic [6:0] V_LDUSE  = 7'b0001111;
  localparam logic [6:0] V_BRANCH = 7'b1111011;
  localparam logic [6:0] V_IMISS  = 7'b0111011;
  localparam logic [6:0] V_FROZEN = 7'b0000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [3:0] s1 = '0, s2 = '0, dst = '0;
  logic       u2 = 1'b0, mr = 1'b0, wr = 1'b0, halt = 1'b0, br = 1'b0, im = 1'b0, dm = 1'b0;

  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, hlt;
  logic [CNT_W-1:0] stall_cycles;

  pipe_hazard_ctrl #(.HALT_DRAIN(HALT_DRAIN), .CNT_W(CNT_W)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_ifid_src_reg1  (s1),
    .i_ifid_src_reg2  (s2),
    .i_ifid_uses_src2 (u2),
    .i_idex_mem_read  (mr),
    .i_idex_write_reg (wr),
    .i_idex_dst_reg   (dst),
    .i_idex_halt      (halt),
    .i_branch_taken   (br),
    .i_imem_stall     (im),
    .i_dmem_stall     (dm),
    .o_pc_en          (pc_en),
    .o_ifid_en        (ifid_en),
    .o_ifid_flush     (ifid_flush),
    .o_idex_en        (idex_en),
    .o_idex_bubble    (idex_bubble),
    .o_exmem_en       (exmem_en),
    .o_memwb_en       (memwb_en),
    .o_hlt            (hlt),
    .o_stall_cycles   (stall_cycles)
  );

  typedef struct packed {
    logic [6:0]       ctrl;
    logic             hlt;
    logic [CNT_W-1:0] stall;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Behavioural model: halted flag, drain countdown in unstalled edges, stall tally.
  bit m_halted     = 1'b0;
  bit m_draining   = 1'b0;
  int m_drain_left = 0;
  int m_stall      = 0;
  bit m_last_pc_en = 1'b1;

  function automatic logic [6:0] ref_ctrl();
    logic lu;
    lu = mr && wr && (dst != 0) && ((dst == s1) || (u2 && (dst == s2)));
    if (!rst_n)     return V_NORMAL;
    if (m_halted)   return V_FROZEN;
    if (m_draining) return {5'b01111, ~dm, ~dm};
    if (dm)         return V_FROZEN;
    if (halt)       return V_HALT;
    if (lu)         return V_LDUSE;
    if (br)         return V_BRANCH;
    if (im)         return V_IMISS;
    return V_NORMAL;
  endfunction

  // Applies one clock edge using the inputs that were present during the cycle.
  task automatic model_edge();
    if (!rst_n) begin
      m_halted   = 1'b0;
      m_draining = 1'b0;
      m_stall    = 0;
    end else begin
      if (!m_halted && !m_last_pc_en && (m_stall < CNT_MAX)) m_stall++;
      if (m_draining) begin
        if (!dm) begin
          if (m_drain_left == 1) begin
            m_halted   = 1'b1;
            m_draining = 1'b0;
          end else begin
            m_drain_left--;
          end
        end
      end else if (!m_halted && !dm && halt) begin
        m_draining   = 1'b1;
        m_drain_left = HALT_DRAIN;
      end
    end
  endtask

  task automatic cycle(input logic i_rst, input logic [3:0] i_s1, input logic [3:0] i_s2,
                       input logic i_u2, input logic i_mr, input logic i_wr, input logic [3:0] i_dst,
                       input logic i_halt, input logic i_br, input logic i_im, input logic i_dm);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    rst_n = i_rst; s1 = i_s1; s2 = i_s2; u2 = i_u2; mr = i_mr; wr = i_wr; dst = i_dst;
    halt = i_halt; br = i_br; im = i_im; dm = i_dm;
    e.ctrl  = ref_ctrl();
    e.hlt   = m_halted;
    e.stall = CNT_W'(m_stall);
    m_last_pc_en = e.ctrl[6];
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  exp_t       mon_e;
  logic [6:0] mon_ctrl;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e    = sb_q.pop_front();
      mon_ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en};
      cyc++;
      $display("cyc %0d: ctrl=%b hlt=%b stall=%0d (exp ctrl=%b hlt=%b stall=%0d)",
               cyc, mon_ctrl, hlt, stall_cycles, mon_e.ctrl, mon_e.hlt, mon_e.stall);
      total++;
      if (mon_ctrl !== mon_e.ctrl) begin
        bad++;
        $display("FAIL ctrl cyc %0d: got %b want %b", cyc, mon_ctrl, mon_e.ctrl);
      end
      total++;
      if (hlt !== mon_e.hlt) begin
        bad++;
        $display("FAIL hlt cyc %0d: got %b want %b", cyc, hlt, mon_e.hlt);
      end
      total++;
      if (stall_cycles !== mon_e.stall) begin
        bad++;
        $display("FAIL stall_cycles cyc %0d: got %0d want %0d", cyc, stall_cycles, mon_e.stall);
      end
    end
  end

  initial begin
    // Reset and a load-use hazard followed by normal flow.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    cycle(1, 3, 0, 0, 1, 1, 3, 0, 0, 0, 0);
    idle(1);
    // R0 is never a hazard; load-use through rt only when rt is read.
    cycle(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 5, 0, 1, 1, 5, 0, 0, 0, 0);
    cycle(1, 1, 5, 1, 1, 1, 5, 0, 0, 0, 0);
    // Taken branch beats a fetch miss; a lone fetch miss stalls.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // Data miss for 4 cycles with a load-use waiting behind it.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle(1, 3, 0, 0, 1, 1, 3, 0, 0, 0, 1);
    cycle(1, 3, 0, 0, 1, 1, 3, 0, 0, 0, 0);
    idle(2);
    // HALT drain with a 3-cycle data miss inside, then sticky halt.
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    for (int k = 0; k < 20; k++) cycle(1, 3, 3, 1, 1, 1, 3, 1, 1, 1, k[0]);
    // Reset while draining.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Random traffic; small register range keeps hazards frequent.
    for (int k = 0; k < 1500; k++) begin
      cycle(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
